// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : Single-outstanding-request fetch unit with a one-entry skid
//            buffer, latched redirect and halt handling.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPC,
    input  logic        halt,
    output logic [31:0] instruction,
    output logic [31:0] debugPC,
    output logic        bubble,
    output logic        halted
);

    typedef enum logic [1:0] {
        START  = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        halted_q, halted_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        halt_pend_q, halt_pend_d;

    logic [31:0] w_redir_tgt;
    logic [31:0] w_next_pc;
    logic        w_consume;
    logic        w_free;
    logic        w_halting;
    logic        w_resp;

    assign w_redir_tgt = redirectPC & 32'hFFFF_FFFC;
    assign w_consume   = out_valid_q & ~stall;
    assign w_free      = ~out_valid_q | ~stall;
    assign w_halting   = halt | halt_pend_q;
    assign w_resp      = (state_q == FETCH) & imemReady;
    // A same-cycle redirect beats one latched earlier in the request.
    assign w_next_pc   = redirect     ? w_redir_tgt :
                         redir_pend_q ? redir_pc_q  : pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_valid_d  = out_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        halt_pend_d  = halt_pend_q;

        if (w_resp && !w_halting && w_free) begin
            out_instr_d = imemData;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
        end else if (w_consume) begin
            if (skid_valid_q) begin
                out_instr_d  = skid_instr_q;
                out_pc_d     = skid_pc_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d  = 1'b0;
            end
        end

        case (state_q)
            START: state_d = FETCH;
            FETCH: begin
                if (imemReady) begin
                    redir_pend_d = 1'b0;
                    if (w_halting) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = w_next_pc;
                        if (!w_free) begin
                            skid_instr_d = imemData;
                            skid_pc_d    = pc_q;
                            skid_valid_d = 1'b1;
                            state_d      = HOLD;
                        end
                    end
                end else begin
                    if (halt) halt_pend_d = 1'b1;
                    if (redirect) begin
                        redir_pend_d = 1'b1;
                        redir_pc_d   = w_redir_tgt;
                    end
                end
            end
            HOLD: begin
                // No request is outstanding here, so halt takes effect at once.
                if (halt) begin
                    state_d = HALTED;
                end else begin
                    if (redirect) pc_d = w_redir_tgt;
                    if (!stall) state_d = FETCH;
                end
            end
            HALTED: ;
            default: state_d = START;
        endcase

        req_d    = (state_d == FETCH);
        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= START;
            req_q        <= 1'b0;
            halted_q     <= 1'b0;
            pc_q         <= RESET_PC;
            out_instr_q  <= 32'd0;
            out_pc_q     <= 32'd0;
            out_valid_q  <= 1'b0;
            skid_instr_q <= 32'd0;
            skid_pc_q    <= 32'd0;
            skid_valid_q <= 1'b0;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= 32'd0;
            halt_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            halted_q     <= halted_d;
            pc_q         <= pc_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_valid_q  <= out_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
            halt_pend_q  <= halt_pend_d;
        end
    end

    assign imemReq     = req_q;
    assign imemAddr    = pc_q;
    assign instruction = out_instr_q;
    assign debugPC     = out_pc_q;
    assign bubble      = ~out_valid_q;
    assign halted      = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Brief    : Directed plus randomized bench for instruction_fetch against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_instruction_fetch;

    localparam logic [31:0] C_RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady = 1'b0;
    logic [31:0] imemData = 32'd0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPC = 32'd0;
    logic        halt = 1'b0;
    logic [31:0] instruction;
    logic [31:0] debugPC;
    logic        bubble;
    logic        halted;

    instruction_fetch #(.RESET_PC(C_RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemReady  (imemReady),
        .imemData   (imemData),
        .stall      (stall),
        .redirect   (redirect),
        .redirectPC (redirectPC),
        .halt       (halt),
        .instruction(instruction),
        .debugPC    (debugPC),
        .bubble     (bubble),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: delivery queue (head = presented word), fetch pointer.
    logic        m_started, m_busy, m_stopped, m_halt_pend, m_pend_v;
    logic [31:0] m_pc, m_pend;
    logic [63:0] m_q[$];

    int mem_cnt = 0;
    int mem_lat = 0;
    bit mem_rand = 1'b0;
    bit mem_noise = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started   = 1'b0;
        m_busy      = 1'b0;
        m_stopped   = 1'b0;
        m_halt_pend = 1'b0;
        m_pend_v    = 1'b0;
        m_pc        = C_RESET_PC;
        m_pend      = 32'd0;
        m_q.delete();
    endtask

    task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic hl, input logic rdy, input logic [31:0] dat);
        logic [31:0] tgt;
        logic        halting;
        if (!m_started) begin
            m_started = 1'b1;
            m_busy    = 1'b1;
            return;
        end
        tgt = {rpc[31:2], 2'b00};
        if (m_q.size() > 0 && !st) void'(m_q.pop_front());
        if (m_stopped) return;
        halting = hl || m_halt_pend;
        if (m_busy) begin
            if (rdy) begin
                if (halting) begin
                    m_stopped = 1'b1;
                    m_busy    = 1'b0;
                end else begin
                    m_q.push_back({m_pc, dat});
                    m_pc     = rd ? tgt : (m_pend_v ? m_pend : m_pc + 32'd4);
                    m_pend_v = 1'b0;
                    m_busy   = (m_q.size() <= 1);
                end
            end else begin
                if (hl) m_halt_pend = 1'b1;
                if (rd) begin
                    m_pend_v = 1'b1;
                    m_pend   = tgt;
                end
            end
        end else if (hl) begin
            m_stopped = 1'b1;
        end else begin
            if (rd) m_pc = tgt;
            m_busy = (m_q.size() <= 1);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] head;
        check("imemReq", 32'(imemReq), 32'(m_busy));
        if (m_busy) check("imemAddr", imemAddr, m_pc);
        check("bubble", 32'(bubble), 32'(m_q.size() == 0));
        if (m_q.size() > 0) begin
            head = m_q[0];
            check("instruction", instruction, head[31:0]);
            check("debugPC", debugPC, head[63:32]);
        end
        check("halted", 32'(halted), 32'(m_stopped));
    endtask

    task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input logic hl);
        logic        rdy;
        logic [31:0] dat;
        @(negedge clk);
        check_outputs();
        rdy = 1'b0;
        dat = $urandom;
        if (imemReq) begin
            if (mem_cnt >= mem_lat) begin
                rdy     = 1'b1;
                dat     = mem_word(imemAddr);
                mem_cnt = 0;
                if (mem_rand) mem_lat = $urandom_range(0, 3);
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_cnt = 0;
            if (mem_noise) rdy = ($urandom_range(0, 3) == 0);
        end
        imemReady  = rdy;
        imemData   = dat;
        stall      = st;
        redirect   = rd;
        redirectPC = rpc;
        halt       = hl;
        model_step(st, rd, rpc, hl, rdy, dat);
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        imemReady  = 1'b1;
        imemData   = 32'hDEAD_BEEF;
        stall      = 1'b0;
        redirect   = 1'b0;
        redirectPC = 32'd0;
        halt       = 1'b0;
        #1;
        check("rst_imemReq", 32'(imemReq), 32'd0);
        check("rst_imemAddr", imemAddr, C_RESET_PC);
        check("rst_instruction", instruction, 32'd0);
        check("rst_debugPC", debugPC, 32'd0);
        check("rst_bubble", 32'(bubble), 32'd1);
        check("rst_halted", 32'(halted), 32'd0);
        model_reset();
        mem_cnt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        // A stray ready during the START cycle must be ignored.
        model_step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    endtask

    initial begin
        logic st, rd, hl;
        #1;
        do_reset();

        // Zero-wait streaming.
        mem_lat = 0; mem_rand = 1'b0; mem_noise = 1'b0;
        cycle(0, 0, 0, 0);
        check("zw_addr0", imemAddr, 32'h3000);
        check("zw_bubble0", 32'(bubble), 32'd1);
        cycle(0, 0, 0, 0);
        check("zw_addr1", imemAddr, 32'h3004);
        check("zw_dpc1", debugPC, 32'h3000);
        check("zw_bubble1", 32'(bubble), 32'd0);
        cycle(0, 0, 0, 0);
        check("zw_addr2", imemAddr, 32'h3008);
        check("zw_dpc2", debugPC, 32'h3004);

        // Redirect during a 3-cycle request: delay slot still delivered.
        #2; do_reset();
        mem_lat = 0;
        cycle(0, 0, 0, 0);
        mem_lat = 2;
        cycle(0, 0, 0, 0);
        check("rd_addr_out", imemAddr, 32'h3004);
        cycle(0, 1, 32'h0000_3101, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("rd_next_addr", imemAddr, 32'h3100);
        check("rd_delay_slot", debugPC, 32'h3004);

        // Stall with output full parks one response in the skid buffer.
        mem_lat = 0;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("st_req_low", 32'(imemReq), 32'd0);
        check("st_bubble", 32'(bubble), 32'd0);
        repeat (3) cycle(1, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 0);

        // Address wrap at the top of memory.
        cycle(0, 1, 32'hFFFF_FFFE, 0);
        cycle(0, 0, 0, 0);
        check("wrap_addr_top", imemAddr, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0);
        check("wrap_addr_zero", imemAddr, 32'h0000_0000);
        check("wrap_dpc", debugPC, 32'hFFFF_FFFC);

        // Reset mid-request.
        check("pre_rst_req", 32'(imemReq), 32'd1);
        #2; do_reset();

        // Halt with a request to 0x3010 outstanding.
        mem_lat = 0;
        repeat (4) cycle(0, 0, 0, 0);
        mem_lat = 3;
        cycle(0, 0, 0, 1);
        check("halt_addr", imemAddr, 32'h3010);
        repeat (3) cycle(0, 0, 0, 0);
        mem_noise = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle($urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, $urandom, 1'b0);
            check("halted_req", 32'(imemReq), 32'd0);
            check("halted_flag", 32'(halted), 32'd1);
        end

        // Randomized traffic with periodic resets.
        mem_rand = 1'b1;
        for (int r = 0; r < 4; r++) begin
            #2; do_reset();
            mem_lat = $urandom_range(0, 3);
            for (int i = 0; i < 150; i++) begin
                st = ($urandom_range(0, 3) == 0);
                rd = ($urandom_range(0, 9) == 0);
                hl = ($urandom_range(0, 99) == 0);
                cycle(st, rd, $urandom, hl);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00003000, meaning the address of the first fetch after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-004 SHALL have port imemReq, output, 1, instruction-memory read request.
REQ-005 SHALL have port imemAddr, output, 32, word address of the current request (bits [1:0] always 0).
REQ-006 SHALL have port imemReady, input, 1, response strobe; imemData valid in that cycle.
REQ-007 SHALL have port imemData, input, 32, returned instruction word.
REQ-008 SHALL have port stall, input, 1, decode stage cannot accept a new instruction this cycle.
REQ-009 SHALL have port redirect, input, 1, branch/jump taken; redirectPC is the next fetch address.
REQ-010 SHALL have port redirectPC, input, 32, target address; bits [1:0] ignored (treated as 0).
REQ-011 SHALL have port halt, input, 1, one-cycle pulse from decode (syscall): stop fetching.
REQ-012 SHALL have port instruction, output, 32, instruction word presented to decode.
REQ-013 SHALL have port debugPC, output, 32, address of the presented instruction.
REQ-014 SHALL have port bubble, output, 1, 1 = instruction/debugPC carry no valid instruction.
REQ-015 SHALL have port halted, output, 1, fetch permanently stopped until reset.

Function
REQ-016 SHALL implement states START, FETCH, HOLD, HALTED; imemReq = 1 exactly in FETCH.
REQ-017 SHALL keep at most one request outstanding; imemAddr SHALL stay stable from request assertion until the cycle imemReady=1.
REQ-018 START -> FETCH on the first clock edge after reset deasserts; first imemAddr = RESET_PC.
REQ-019 Output register (instruction, debugPC, valid) is consumed in a cycle where valid=1 and stall=0; bubble = !valid.
REQ-020 FETCH with imemReady=1: if output empty or consumed this cycle, load imemData/imemAddr into output (valid next cycle) and stay in FETCH; else capture into a one-entry skid buffer and go to HOLD.
REQ-021 HOLD: imemReq=0; when stall=0, output is consumed, skid moves to output the same edge, state -> FETCH.
REQ-022 If output is consumed with no new load, valid SHALL clear (bubble=1) next cycle.
REQ-023 Next fetch address after a response = pc+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-024 redirect never cancels an outstanding request; that response (delay slot) SHALL be delivered normally.
REQ-025 redirect while a request is outstanding SHALL be latched; the next request issued SHALL use {redirectPC[31:2],2'b00}.
REQ-026 redirect in the same cycle as imemReady SHALL take priority over pc+4 for the next address.
REQ-027 redirect in HOLD SHALL overwrite pc directly; a second redirect before it is used SHALL replace the first.
REQ-028 halt SHALL be latched; once no request is outstanding, state -> HALTED; a response completing the outstanding request SHALL be discarded.
REQ-029 HALTED: imemReq=0, halted=1, output valid SHALL clear after current output is consumed; all inputs except reset ignored.
REQ-030 halt and redirect together: halt wins; no further request is issued.
REQ-031 stall SHALL never affect imemReq or imemAddr of an outstanding request.

Reset
REQ-032 While reset=0: state START, imemReq=0, imemAddr=RESET_PC, instruction=0, debugPC=0, bubble=1, halted=0, skid empty, latched redirect/halt cleared.
REQ-033 Reset asserted mid-request SHALL abort immediately; a later imemReady SHALL be ignored until a new request is issued.

Verification
REQ-034 Zero-wait memory (imemReady=1 when requested), stall=0 -> addresses 0x3000,0x3004,0x3008 on consecutive cycles, debugPC follows one cycle later, bubble=0 from cycle 3.
REQ-035 3-cycle memory latency, redirect=1 redirectPC=0x3101 during 2nd cycle of request to 0x3004 -> 0x3004 delivered, next imemAddr=0x3100.
REQ-036 stall held high 5 cycles with output full -> one response captured in HOLD, imemReq=0, no instruction lost or duplicated; release -> in-order delivery.
REQ-037 halt pulse with request to 0x3010 outstanding -> response discarded, halted=1, imemReq stays 0 for 20 cycles.
REQ-038 pc=0xFFFFFFFC fetch -> next imemAddr=0x00000000.
REQ-039 reset pulled low while imemReq=1 -> imemReq=0 same cycle, bubble=1; after release first imemAddr=RESET_PC.
